regfile_sb: RTL

- Parametrised register file for the CPU datapath with two read ports and two write ports. Port W is the ALU/single-cycle path; port B is the multicycle/load writeback path.
- Adds write-through bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard for multicycle results.
- Adds a sequenced clear operation that zeroes the file one entry per cycle.
- Sits between decode (read/issue) and writeback stages.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/regfile_sb_bypass.sv | 42 ++++
 rtl/regfile_sb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register-file clear FSM states and default geometry.
package cpu_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

endpackage

// File: rtl/regfile_sb_bypass.sv
// One read port: zero-register, port W, port B, then array priority mux,
// plus pending-bit forward (a same-cycle writeback hides the pending bit).
module regfile_sb_bypass
    import cpu_pkg::*;
#(
    parameter int WIDTH     = RF_WIDTH,
    parameter int AW        = 5,
    parameter int ZERO_REG0 = 1
) (
    input  logic [AW-1:0]    rd_addr_i,
    input  logic             wr_fwd_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wb_fwd_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic [WIDTH-1:0] arr_data_i,
    input  logic             arr_pend_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_pend_o
);

    logic wr_hit;
    logic wb_hit;

    assign wr_hit = wr_fwd_i && (wr_addr_i == rd_addr_i);
    assign wb_hit = wb_fwd_i && (wb_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = arr_data_i;
        rd_pend_o = arr_pend_i && !wb_hit;
        if ((ZERO_REG0 != 0) && (rd_addr_i == '0)) begin
            rd_data_o = '0;
            rd_pend_o = 1'b0;
        end else if (wr_hit) begin
            rd_data_o = wr_data_i;
        end else if (wb_hit) begin
            rd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// 2R/2W register file with write-through bypass, pending scoreboard for
// multicycle results, and a one-entry-per-cycle clear sequence.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int WIDTH     = RF_WIDTH,
    parameter int DEPTH     = RF_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int ZERO_REG0 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr_1,
    input  logic [AW-1:0]    rd_addr_2,
    output logic [WIDTH-1:0] rd_data_1,
    output logic [WIDTH-1:0] rd_data_2,
    output logic             rd_pend_1,
    output logic             rd_pend_2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             clr_req,
    output logic             busy
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;

    logic idle;
    logic wr_fwd, wb_fwd;
    logic wr_ok, wb_ok, iss_ok;

    // While clearing, all normal ports are inert: no state change and no bypass.
    assign idle   = (state_q == RF_IDLE);
    assign wr_fwd = idle && wr_en;
    assign wb_fwd = idle && wb_en;
    assign wr_ok  = wr_fwd && !((ZERO_REG0 != 0) && (wr_addr == '0));
    assign wb_ok  = wb_fwd && !((ZERO_REG0 != 0) && (wb_addr == '0));
    assign iss_ok = idle && iss_en && !((ZERO_REG0 != 0) && (iss_addr == '0));
    assign busy   = !idle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        pend_d  = pend_q;
        case (state_q)
            RF_IDLE: begin
                // Port W applied after port B so W wins a same-address collision;
                // issue applied after writeback so a new issue keeps the bit set.
                if (wb_ok) begin
                    mem_d[wb_addr]  = wb_data;
                    pend_d[wb_addr] = 1'b0;
                end
                if (wr_ok) begin
                    mem_d[wr_addr] = wr_data;
                end
                if (iss_ok) begin
                    pend_d[iss_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                mem_d[cnt_q]  = '0;
                pend_d[cnt_q] = 1'b0;
                cnt_d         = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            mem_q   <= mem_d;
        end
    end

    regfile_sb_bypass #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG0(ZERO_REG0)) u_byp_1 (
        .rd_addr_i  (rd_addr_1),
        .wr_fwd_i   (wr_fwd),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wb_fwd_i   (wb_fwd),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .arr_data_i (mem_q[rd_addr_1]),
        .arr_pend_i (pend_q[rd_addr_1]),
        .rd_data_o  (rd_data_1),
        .rd_pend_o  (rd_pend_1)
    );

    regfile_sb_bypass #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG0(ZERO_REG0)) u_byp_2 (
        .rd_addr_i  (rd_addr_2),
        .wr_fwd_i   (wr_fwd),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wb_fwd_i   (wb_fwd),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .arr_data_i (mem_q[rd_addr_2]),
        .arr_pend_i (pend_q[rd_addr_2]),
        .rd_data_o  (rd_data_2),
        .rd_pend_o  (rd_pend_2)
    );

endmodule
